mcp_accum_core: RTL
===================

MCP_ACCUM_CORE -- requirements
Module: mcp_accum_core

Interface
REQ-001 Parameters SHALL be: DATA_W, 8, accumulator/data width (>=4); ADDR_W, 5, PC and data-address width (>=2); instruction width is fixed at 3+ADDR_W.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 start  in  1  begin execution from PC=0; honoured only in IDLE or HALT.
REQ-005 im_addr  out  ADDR_W  instruction address, equal to PC.
REQ-006 im_data  in  3+ADDR_W  instruction: opcode [ADDR_W+2:ADDR_W], operand address [ADDR_W-1:0]; combinational read.
REQ-007 dm_addr  out  ADDR_W  data address; dm_we  out  1  write strobe; dm_wdata  out  DATA_W  write data.
REQ-008 dm_rdata  in  DATA_W  data memory read; valid one cycle after dm_addr is presented (synchronous read).
REQ-009 io_in  in  DATA_W, io_in_valid  in  1, io_in_ready  out  1  input handshake.
REQ-010 io_out  out  DATA_W, io_out_valid  out  1, io_out_ready  in  1  output handshake.
REQ-011 acc  out  DATA_W accumulator; zero  out  1 (acc==0); carry  out  1 flag; halted  out  1 (state==HALT).

Function
REQ-012 Opcodes SHALL be: 000 HALT, 001 LOAD, 010 STORE, 011 ADD, 100 SUB, 101 SHL, 110 IN, 111 OUT.
REQ-013 FSM states SHALL be IDLE, FETCH, EXEC, MEM, IO, HALT.
REQ-014 IDLE/HALT: start=1 -> PC<=0, next FETCH; otherwise hold; start is ignored in all other states.
REQ-015 FETCH: IR<=im_data, PC<=PC+1 modulo 2^ADDR_W (wraps silently), next EXEC.
REQ-016 EXEC: dm_addr=IR operand; LOAD/ADD/SUB -> MEM; STORE: dm_we=1 and dm_wdata=acc for exactly this cycle, -> FETCH; SHL: acc<={acc[DATA_W-2:0],0}, carry<=acc[DATA_W-1], -> FETCH; IN/OUT -> IO; HALT -> HALT.
REQ-017 MEM: dm_addr is held; LOAD acc<=dm_rdata (carry unchanged); ADD {carry,acc}<=acc+dm_rdata; SUB acc<=acc-dm_rdata modulo 2^DATA_W, carry<=(acc<dm_rdata unsigned); -> FETCH.
REQ-018 IO/IN: io_in_ready=1; on io_in_valid=1, acc<=io_in in the same cycle, -> FETCH; otherwise wait indefinitely.
REQ-019 IO/OUT: io_out_valid=1 and io_out=acc, stable while waiting; on io_out_ready=1, -> FETCH; acc is unchanged.
REQ-020 Instruction latency SHALL be: LOAD/ADD/SUB 3 cycles; STORE/SHL/HALT 2 cycles; IN/OUT 3 cycles plus handshake wait cycles.
REQ-021 io_in_ready, io_out_valid and dm_we SHALL be 0 in every state other than those stated above.
REQ-022 dm_addr SHALL be 0 outside EXEC/MEM; dm_wdata SHALL equal acc at all times.

Reset
REQ-023 Asserting reset in any state, including mid-instruction or during a pending handshake, SHALL immediately force: state=IDLE, PC=0, IR=0, acc=0, carry=0.
REQ-024 While reset is asserted, outputs SHALL be: im_addr=0, dm_addr=0, dm_we=0, io_in_ready=0, io_out_valid=0, io_out=0, zero=1, halted=0.
REQ-025 After reset deasserts, no instruction SHALL execute until start is sampled high.

Structure
REQ-026 The opcode encoding enum, the FSM state enum and the instruction field offsets SHALL live in a shared package mcp_pkg.
REQ-027 Arithmetic SHALL be isolated in one combinational sub-module, mcp_alu (DATA_W parameter; ADD/SUB/SHL/pass; result plus carry).

Verification
REQ-028 LOAD 3 (M[3]=0x7F); ADD 4 (M[4]=0x81) -> acc=0x00, carry=1, zero=1.
REQ-029 LOAD 5 (M[5]=0x02); SUB 6 (M[6]=0x03) -> acc=0xFF, carry=1; then SHL -> acc=0xFE, carry=1.
REQ-030 IN with io_in_valid held low for 4 cycles, then io_in=0x5A -> io_in_ready high for 5 cycles; acc=0x5A; next FETCH follows on the next edge.
REQ-031 OUT with io_out_ready low for 3 cycles -> io_out_valid=1 and io_out=acc stable for 4 cycles; STORE 9 -> dm_we pulses for one cycle with dm_addr=9.
REQ-032 Program of 32 non-HALT instructions (ADDR_W=5) -> PC wraps 31->0; HALT -> halted=1; start restarts from PC=0.
REQ-033 Reset asserted during MEM of ADD and during the IO wait -> outputs match REQ-024 asynchronously; acc=0 after release.

Source files
------------

// File: rtl/mcp_pkg.sv
// Shared definitions for the MCP accumulator core: opcode and FSM state
// encodings, ALU operation select, and instruction field layout.
// No ports (package).
package mcp_pkg;

    // Instruction layout: {opcode[OPC_W-1:0], operand[ADDR_W-1:0]}.
    // The operand sits at bit 0 and the opcode directly above it.
    localparam int OPC_W    = 3;
    localparam int OPND_LSB = 0;

    typedef enum logic [2:0] {
        OP_HALT  = 3'b000,
        OP_LOAD  = 3'b001,
        OP_STORE = 3'b010,
        OP_ADD   = 3'b011,
        OP_SUB   = 3'b100,
        OP_SHL   = 3'b101,
        OP_IN    = 3'b110,
        OP_OUT   = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_IO    = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ALU_PASS = 2'd0,
        ALU_ADD  = 2'd1,
        ALU_SUB  = 2'd2,
        ALU_SHL  = 2'd3
    } alu_op_t;

    // Bit position of the opcode LSB for a given address width.
    function automatic int opc_lsb(input int addr_w);
        return addr_w;
    endfunction

endpackage

// File: rtl/mcp_alu.sv
// Purpose: combinational accumulator ALU (pass-through, add, subtract, shift-left).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; result is valid whenever inputs are.
// Ports: i_op operation select, i_a accumulator operand, i_b memory operand,
//        o_res result, o_carry carry/borrow/shifted-out bit (0 for pass).
module mcp_alu
    import mcp_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  alu_op_t           i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_res,
    output logic              o_carry
);

    always_comb begin
        o_res   = i_b;
        o_carry = 1'b0;
        case (i_op)
            ALU_ADD: {o_carry, o_res} = {1'b0, i_a} + {1'b0, i_b};
            ALU_SUB: begin
                o_res   = i_a - i_b;
                o_carry = (i_a < i_b);   // borrow
            end
            ALU_SHL: begin
                o_res   = {i_a[DATA_W-2:0], 1'b0};
                o_carry = i_a[DATA_W-1];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mcp_accum_core.sv
// Purpose: multi-cycle accumulator CPU (FETCH/EXEC/MEM/IO FSM) with external
//          instruction memory, synchronous-read data memory and an I/O handshake.
// Latency: LOAD/ADD/SUB 3 cycles, STORE/SHL/HALT 2 cycles, IN/OUT 3 cycles plus
//          handshake wait; backpressure: IO state stalls until io_in_valid / io_out_ready.
// Ports: clk/reset (async, active-high), start; im_addr/im_data instruction fetch;
//        dm_addr/dm_we/dm_wdata/dm_rdata data memory; io_in* and io_out* handshakes;
//        acc/zero/carry/halted architectural status.
module mcp_accum_core
    import mcp_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic [ADDR_W-1:0]       im_addr,
    input  logic [OPC_W+ADDR_W-1:0] im_data,
    output logic [ADDR_W-1:0]       dm_addr,
    output logic                    dm_we,
    output logic [DATA_W-1:0]       dm_wdata,
    input  logic [DATA_W-1:0]       dm_rdata,
    input  logic [DATA_W-1:0]       io_in,
    input  logic                    io_in_valid,
    output logic                    io_in_ready,
    output logic [DATA_W-1:0]       io_out,
    output logic                    io_out_valid,
    input  logic                    io_out_ready,
    output logic [DATA_W-1:0]       acc,
    output logic                    zero,
    output logic                    carry,
    output logic                    halted
);

    localparam int OPC_LSB = opc_lsb(ADDR_W);
    localparam int INSTR_W = OPC_W + ADDR_W;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [INSTR_W-1:0]  r_ir;
    logic [DATA_W-1:0]   r_acc;
    logic                r_carry;
    logic                r_dm_we;
    logic                r_io_in_ready;
    logic                r_io_out_valid;

    opcode_t             w_fetch_op;
    opcode_t             w_ir_op;
    alu_op_t             w_alu_op;
    logic [DATA_W-1:0]   w_alu_res;
    logic                w_alu_carry;

    assign w_fetch_op = opcode_t'(im_data[OPC_LSB +: OPC_W]);
    assign w_ir_op    = opcode_t'(r_ir[OPC_LSB +: OPC_W]);

    always_comb begin
        w_alu_op = ALU_PASS;
        case (w_ir_op)
            OP_ADD:  w_alu_op = ALU_ADD;
            OP_SUB:  w_alu_op = ALU_SUB;
            OP_SHL:  w_alu_op = ALU_SHL;
            default: w_alu_op = ALU_PASS;
        endcase
    end

    // Memory operand arrives one cycle after dm_addr, i.e. during MEM.
    mcp_alu #(.DATA_W(DATA_W)) u_alu (
        .i_op    (w_alu_op),
        .i_a     (r_acc),
        .i_b     (dm_rdata),
        .o_res   (w_alu_res),
        .o_carry (w_alu_carry)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_pc           <= '0;
            r_ir           <= '0;
            r_acc          <= '0;
            r_carry        <= 1'b0;
            r_dm_we        <= 1'b0;
            r_io_in_ready  <= 1'b0;
            r_io_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        r_pc    <= '0;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_ir    <= im_data;
                    r_pc    <= r_pc + ADDR_W'(1);
                    // Write strobe is decided at fetch so it is a clean
                    // register output for exactly the EXEC cycle.
                    r_dm_we <= (w_fetch_op == OP_STORE);
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_dm_we <= 1'b0;
                    case (w_ir_op)
                        OP_LOAD, OP_ADD, OP_SUB: r_state <= S_MEM;
                        OP_STORE: r_state <= S_FETCH;
                        OP_SHL: begin
                            r_acc   <= w_alu_res;
                            r_carry <= w_alu_carry;
                            r_state <= S_FETCH;
                        end
                        OP_IN: begin
                            r_io_in_ready <= 1'b1;
                            r_state       <= S_IO;
                        end
                        OP_OUT: begin
                            r_io_out_valid <= 1'b1;
                            r_state        <= S_IO;
                        end
                        default: r_state <= S_HALT;
                    endcase
                end
                S_MEM: begin
                    r_acc <= w_alu_res;
                    // LOAD leaves the carry flag untouched.
                    if (w_ir_op != OP_LOAD) begin
                        r_carry <= w_alu_carry;
                    end
                    r_state <= S_FETCH;
                end
                S_IO: begin
                    if (r_io_in_ready && io_in_valid) begin
                        r_acc         <= io_in;
                        r_io_in_ready <= 1'b0;
                        r_state       <= S_FETCH;
                    end else if (r_io_out_valid && io_out_ready) begin
                        r_io_out_valid <= 1'b0;
                        r_state        <= S_FETCH;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Data address is only meaningful while the operand is in use.
    assign dm_addr      = (r_state == S_EXEC || r_state == S_MEM) ? r_ir[OPND_LSB +: ADDR_W] : '0;
    assign im_addr      = r_pc;
    assign dm_we        = r_dm_we;
    assign dm_wdata     = r_acc;
    assign io_in_ready  = r_io_in_ready;
    assign io_out_valid = r_io_out_valid;
    assign io_out       = r_acc;
    assign acc          = r_acc;
    assign zero         = (r_acc == '0);
    assign carry        = r_carry;
    assign halted       = (r_state == S_HALT);

endmodule
